// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and line levels.
// Used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Bit-timing and payload shifter for the UART transmitter: holds the frame byte,
// counts PRESCALE cycles per bit and payload bits, and flags bit/payload boundaries.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  active,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  cur_bit,
  output logic                  bit_done,
  output logic                  data_done
);

  localparam int            EW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [EW-1:0]         edge_cnt_q, edge_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;

  assign cur_bit   = shift_q[0];
  assign bit_done  = active && (edge_cnt_q == EDGE_LAST);
  assign data_done = advance && (bit_cnt_q == BIT_LAST);

  always_comb begin
    shift_d    = shift_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (load) begin
      shift_d    = load_data;
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (active) begin
      edge_cnt_d = bit_done ? '0 : edge_cnt_q + 1'b1;
      // advance is only asserted on a bit boundary inside the payload
      if (advance) begin
        shift_d   = shift_q >> 1;
        bit_cnt_d = data_done ? '0 : bit_cnt_q + 1'b1;
      end
    end else begin
      edge_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      shift_q    <= shift_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter: start bit, DATA_WIDTH bits LSB first, optional parity, stop bit,
// each held PRESCALE cycles. All outputs come straight from flops.
module uart_tx_top
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  parity_en,
  input  logic                  parity_type,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_done
);

  uart_state_e state_q, state_d;
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
  logic tx_q, tx_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic load, active, advance;
  logic cur_bit, bit_done, data_done;

  assign active  = (state_q != ST_IDLE);
  assign load    = (state_q == ST_IDLE) && data_valid;
  assign advance = (state_q == ST_DATA) && bit_done;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .PRESCALE  (PRESCALE)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .active   (active),
    .advance  (advance),
    .load_data(p_data),
    .cur_bit  (cur_bit),
    .bit_done (bit_done),
    .data_done(data_done)
  );

  // Line level is derived from the current state and registered, so tx_out
  // trails the FSM by one cycle and every bit still lasts PRESCALE cycles.
  always_comb begin
    state_d   = state_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = IDLE_LVL;
    case (state_q)
      ST_IDLE: begin
        tx_d = IDLE_LVL;
        if (data_valid) begin
          state_d   = ST_START;
          par_en_d  = parity_en;
          par_bit_d = (^p_data) ^ (parity_type == PAR_ODD);
        end
      end
      ST_START: begin
        tx_d = START_LVL;
        if (bit_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        tx_d = cur_bit;
        if (data_done) state_d = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        tx_d = par_bit_q;
        if (bit_done) state_d = ST_STOP;
      end
      ST_STOP: begin
        tx_d = STOP_LVL;
        if (bit_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = active;
    // First cycle back in IDLE while busy is still high marks the stop bit's end.
    done_d = busy_q && (state_q == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= IDLE_LVL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_out  = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_top.sv
// Directed bench for uart_tx_top at PRESCALE=8: frame shapes, parity, ignored
// requests, back-to-back frames and mid-frame asynchronous reset.
module tb_uart_tx_top;

  localparam int DW = 8;
  localparam int PS = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] p_data = '0;
  logic          data_valid = 1'b0;
  logic          parity_en = 1'b0;
  logic          parity_type = 1'b0;
  logic          tx_out, busy, tx_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  uart_tx_top #(.DATA_WIDTH(DW), .PRESCALE(PS)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .parity_en  (parity_en),
    .parity_type(parity_type),
    .tx_out     (tx_out),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  // Expected line level k cycles after the accepting edge (k=1 is the first start cycle).
  function automatic logic exp_line(input logic [7:0] d, input logic pe, input logic pbit, input int k);
    int nb = pe ? 11 : 10;
    int b;
    if (k < 1 || k > nb * PS) return 1'b1;
    b = (k - 1) / PS;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pe && b == 9) return pbit;
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (tx_out !== 1'b1) $display("FAIL reset_tx got %b want 1", tx_out); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (tx_done !== 1'b0) $display("FAIL reset_done got %b want 0", tx_done); else pass_cnt++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (tx_out !== 1'b1 || busy !== 1'b0) $display("FAIL idle_after_reset got tx=%b busy=%b want tx=1 busy=0", tx_out, busy); else pass_cnt++;
  endtask

  task automatic test_plain();
    logic [9:0] seq = 10'b1101001010;  // 0xA5 framed: 0,1,0,1,0,0,1,0,1,1
    logic e;
    int done_cnt = 0;
    p_data = 8'hA5; parity_en = 1'b0; parity_type = 1'b0; data_valid = 1'b1;
    for (int k = 0; k <= 82; k++) begin
      @(negedge clk);
      if (k == 0) data_valid = 1'b0;
      e = (k >= 1 && k <= 80) ? seq[(k-1)/8] : 1'b1;
      total_cnt++; if (tx_out !== e) $display("FAIL plain_tx k=%0d got %b want %b", k, tx_out, e); else pass_cnt++;
      total_cnt++; if (busy !== (k >= 1 && k <= 80)) $display("FAIL plain_busy k=%0d got %b want %b", k, busy, (k >= 1 && k <= 80)); else pass_cnt++;
      total_cnt++; if (tx_done !== (k == 81)) $display("FAIL plain_done k=%0d got %b want %b", k, tx_done, (k == 81)); else pass_cnt++;
      if (tx_done === 1'b1) done_cnt++;
    end
    total_cnt++; if (done_cnt != 1) $display("FAIL plain_done_count got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_parity();
    logic [7:0] pd [4];
    logic       pt [4];
    logic       pb [4];
    logic       e;
    pd = '{8'hA5, 8'h00, 8'hFF, 8'h07};
    pt = '{1'b0, 1'b1, 1'b1, 1'b0};
    pb = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int f = 0; f < 4; f++) begin
      p_data = pd[f]; parity_en = 1'b1; parity_type = pt[f]; data_valid = 1'b1;
      for (int k = 0; k <= 90; k++) begin
        @(negedge clk);
        if (k == 0) data_valid = 1'b0;
        e = exp_line(pd[f], 1'b1, pb[f], k);
        total_cnt++; if (tx_out !== e) $display("FAIL parity_tx f=%0d k=%0d got %b want %b", f, k, tx_out, e); else pass_cnt++;
        total_cnt++; if (busy !== (k >= 1 && k <= 88)) $display("FAIL parity_busy f=%0d k=%0d got %b want %b", f, k, busy, (k >= 1 && k <= 88)); else pass_cnt++;
        total_cnt++; if (tx_done !== (k == 89)) $display("FAIL parity_done f=%0d k=%0d got %b want %b", f, k, tx_done, (k == 89)); else pass_cnt++;
      end
    end
    parity_en = 1'b0; parity_type = 1'b0;
  endtask

  task automatic test_ignore();
    logic e;
    p_data = 8'h3C; parity_en = 1'b0; parity_type = 1'b0; data_valid = 1'b1;
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      if (k == 0) data_valid = 1'b0;
      e = exp_line(8'h3C, 1'b0, 1'b0, k);
      total_cnt++; if (tx_out !== e) $display("FAIL ignore_tx k=%0d got %b want %b", k, tx_out, e); else pass_cnt++;
      total_cnt++; if (busy !== (k >= 1 && k <= 80)) $display("FAIL ignore_busy k=%0d got %b want %b", k, busy, (k >= 1 && k <= 80)); else pass_cnt++;
      total_cnt++; if (tx_done !== (k == 81)) $display("FAIL ignore_done k=%0d got %b want %b", k, tx_done, (k == 81)); else pass_cnt++;
      if (k == 20) begin data_valid = 1'b1; p_data = 8'h99; end
      if (k == 21) data_valid = 1'b0;
      if (k == 30) parity_en = 1'b1;
    end
    parity_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic e;
    logic eb, ed;
    int   j;
    int   done_cnt = 0;
    p_data = 8'h55; parity_en = 1'b0; parity_type = 1'b0; data_valid = 1'b1;
    for (int k = 0; k <= 244; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 243) begin
        j  = ((k - 1) % 81) + 1;
        e  = (j <= 80) ? exp_line(8'h55, 1'b0, 1'b0, j) : 1'b1;
        eb = (j <= 80);
        ed = (j == 81);
      end else begin
        e = 1'b1; eb = 1'b0; ed = 1'b0;
      end
      total_cnt++; if (tx_out !== e) $display("FAIL b2b_tx k=%0d got %b want %b", k, tx_out, e); else pass_cnt++;
      total_cnt++; if (busy !== eb) $display("FAIL b2b_busy k=%0d got %b want %b", k, busy, eb); else pass_cnt++;
      total_cnt++; if (tx_done !== ed) $display("FAIL b2b_done k=%0d got %b want %b", k, tx_done, ed); else pass_cnt++;
      if (tx_done === 1'b1) done_cnt++;
      if (k == 162) data_valid = 1'b0;
    end
    total_cnt++; if (done_cnt != 3) $display("FAIL b2b_done_count got %0d want 3", done_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic e;
    p_data = 8'h00; parity_en = 1'b0; parity_type = 1'b0; data_valid = 1'b1;
    for (int k = 0; k <= 35; k++) begin
      @(negedge clk);
      if (k == 0) data_valid = 1'b0;
      e = exp_line(8'h00, 1'b0, 1'b0, k);
      total_cnt++; if (tx_out !== e) $display("FAIL rmid_tx k=%0d got %b want %b", k, tx_out, e); else pass_cnt++;
    end
    rst = 1'b1;
    #1;
    total_cnt++; if (tx_out !== 1'b1) $display("FAIL rmid_async_tx got %b want 1", tx_out); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rmid_async_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (tx_done !== 1'b0) $display("FAIL rmid_async_done got %b want 0", tx_done); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    p_data = 8'hA5; parity_en = 1'b1; parity_type = 1'b1; data_valid = 1'b1;
    for (int k = 0; k <= 90; k++) begin
      @(negedge clk);
      if (k == 0) data_valid = 1'b0;
      e = exp_line(8'hA5, 1'b1, 1'b1, k);
      total_cnt++; if (tx_out !== e) $display("FAIL rmid_new_tx k=%0d got %b want %b", k, tx_out, e); else pass_cnt++;
      total_cnt++; if (busy !== (k >= 1 && k <= 88)) $display("FAIL rmid_new_busy k=%0d got %b want %b", k, busy, (k >= 1 && k <= 88)); else pass_cnt++;
      total_cnt++; if (tx_done !== (k == 89)) $display("FAIL rmid_new_done k=%0d got %b want %b", k, tx_done, (k == 89)); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_parity();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
